// File: rtl/led_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_counter_pkg
//  Description : Shared widths, state encoding and defaults for led_counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_counter_pkg;

    localparam int CNT_W             = 8;
    localparam int DIV_DEFAULT       = 50_000_000;
    localparam int DB_CYCLES_DEFAULT = 1_000_000;

    typedef enum logic [0:0] {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    // True when a step in the given direction leaves the 8-bit range.
    function automatic logic is_wrap(input logic [CNT_W-1:0] c, input logic dir_up);
        return dir_up ? (&c) : (~|c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_counter_if
//  Description : Board-side buttons/switches and count outputs of led_counter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_counter_if;
    import led_counter_pkg::*;

    logic             btn_run;
    logic             btn_load;
    logic [CNT_W-1:0] sw;
    logic             up;
    logic [CNT_W-1:0] cnt_data;
    logic             running;
    logic             wrap;

    modport master (
        output btn_run, btn_load, sw, up,
        input  cnt_data, running, wrap
    );

    modport slave (
        input  btn_run, btn_load, sw, up,
        output cnt_data, running, wrap
    );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-FF synchroniser, stability counter and one-cycle press pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import led_counter_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic raw,
    output logic      press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], raw};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES)) begin
                // Only the 0->1 flip of the level counts as a press.
                r_level <= ~r_level;
                r_cnt   <= '0;
                r_press <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_counter.sv
`default_nettype none
// ============================================================================
//  Module      : led_counter
//  Description : Pausable, loadable up/down 8-bit counter stepping once per DIV.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_counter
    import led_counter_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    led_counter_if.slave bus
);

    localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic             w_run_press;
    logic             w_load_press;
    logic             w_tick;
    logic [1:0]       r_up_sync;
    logic [CNT_W-1:0] r_sw_s1;
    logic [CNT_W-1:0] r_sw_s2;
    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_run),
        .press (w_run_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_load),
        .press (w_load_press)
    );

    assign w_tick = (r_state == RUN) && (r_pre == PRE_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_sync <= '0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_state   <= PAUSE;
            r_pre     <= '0;
            r_cnt     <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_up_sync <= {r_up_sync[0], bus.up};
            r_sw_s1   <= bus.sw;
            r_sw_s2   <= r_sw_s1;
            r_wrap    <= 1'b0;

            // Prescaler holds in PAUSE so a resume finishes the partial period.
            if (r_state == RUN) begin
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
            end

            if (w_tick) begin
                r_cnt  <= r_up_sync[1] ? r_cnt + 1'b1 : r_cnt - 1'b1;
                r_wrap <= is_wrap(r_cnt, r_up_sync[1]);
            end

            // A load overrides a coincident tick, including its wrap.
            if (w_load_press) begin
                r_cnt  <= r_sw_s2;
                r_pre  <= '0;
                r_wrap <= 1'b0;
            end

            if (w_run_press) begin
                r_state <= (r_state == RUN) ? PAUSE : RUN;
            end
        end
    end

    assign bus.cnt_data = r_cnt;
    assign bus.running  = (r_state == RUN);
    assign bus.wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_counter
//  Description : Directed, table-driven self-checking bench for led_counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_counter;
    import led_counter_pkg::*;

    typedef struct {
        logic [7:0] load;
        logic       dir_up;
        logic [7:0] next1;
        logic       wrap1;
        logic [7:0] next2;
        logic       wrap2;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nvec  = 0;
    int   nfail = 0;
    vec_t vecs[7];

    led_counter_if bus ();

    led_counter #(.DIV(4), .DB_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raw press held long enough to debounce; returns in the cycle the action is visible.
    task automatic press(input bit is_load);
        if (is_load) bus.btn_load = 1'b1;
        else         bus.btn_run  = 1'b1;
        step(6);
        bus.btn_load = 1'b0;
        bus.btn_run  = 1'b0;
        step(1);
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b1, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 8'hFF, 1'b1, 8'hFE, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 8'hFE, 1'b0, 8'hFD, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 8'h7F, 1'b0, 8'h7E, 1'b0};
        vecs[5] = '{8'h7F, 1'b1, 8'h80, 1'b0, 8'h81, 1'b0};
        vecs[6] = '{8'h01, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1};

        bus.btn_run  = 1'b0;
        bus.btn_load = 1'b0;
        bus.sw       = 8'h00;
        bus.up       = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("reset_cnt",  bus.cnt_data, 8'h00);
        chk("reset_run",  8'(bus.running), 8'h00);
        chk("reset_wrap", 8'(bus.wrap), 8'h00);

        // Run from reset: first step DIV cycles after running rises.
        press(1'b0);
        chk("start_running", 8'(bus.running), 8'h01);
        chk("start_cnt", bus.cnt_data, 8'h00);
        step(3);
        chk("start_hold", bus.cnt_data, 8'h00);
        step(1);
        chk("start_step1", bus.cnt_data, 8'h01);
        step(4);
        chk("start_step2", bus.cnt_data, 8'h02);

        // Table: load while running, then two steps in the given direction.
        for (int i = 0; i < 7; i++) begin
            bus.up = vecs[i].dir_up;
            step(3);
            bus.sw = vecs[i].load;
            press(1'b1);
            chk("vec_load", bus.cnt_data, vecs[i].load);
            chk("vec_load_wrap", 8'(bus.wrap), 8'h00);
            step(3);
            chk("vec_hold", bus.cnt_data, vecs[i].load);
            step(1);
            chk("vec_next1", bus.cnt_data, vecs[i].next1);
            chk("vec_wrap1", 8'(bus.wrap), 8'(vecs[i].wrap1));
            step(1);
            chk("vec_wrap1_end", 8'(bus.wrap), 8'h00);
            step(3);
            chk("vec_next2", bus.cnt_data, vecs[i].next2);
            chk("vec_wrap2", 8'(bus.wrap), 8'(vecs[i].wrap2));
            step(1);
            chk("vec_wrap2_end", 8'(bus.wrap), 8'h00);
        end

        // Load press collides with the tick that would wrap FF->00.
        bus.up = 1'b1;
        bus.sw = 8'hFD;
        step(3);
        press(1'b1);
        chk("col_load", bus.cnt_data, 8'hFD);
        step(4);
        chk("col_fe", bus.cnt_data, 8'hFE);
        step(1);
        bus.sw       = 8'hA5;
        bus.btn_load = 1'b1;
        step(6);
        chk("col_ff", bus.cnt_data, 8'hFF);
        bus.btn_load = 1'b0;
        step(1);
        chk("col_a5", bus.cnt_data, 8'hA5);
        chk("col_nowrap", 8'(bus.wrap), 8'h00);
        step(3);
        chk("col_a5_hold", bus.cnt_data, 8'hA5);
        step(1);
        chk("col_a6", bus.cnt_data, 8'hA6);
        chk("col_a6_wrap", 8'(bus.wrap), 8'h00);

        // Pause with the prescaler at 2, then resume.
        step(3);
        press(1'b0);
        chk("pause_running", 8'(bus.running), 8'h00);
        chk("pause_cnt", bus.cnt_data, 8'hA8);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("pause_hold", bus.cnt_data, 8'hA8);
        end
        press(1'b0);
        chk("resume_running", 8'(bus.running), 8'h01);
        chk("resume_cnt", bus.cnt_data, 8'hA8);
        step(1);
        chk("resume_hold", bus.cnt_data, 8'hA8);
        step(1);
        chk("resume_step", bus.cnt_data, 8'hA9);

        // Bounce: a 2-cycle glitch is ignored, a stable press toggles once.
        step(4);
        bus.btn_run = 1'b1;
        step(2);
        bus.btn_run = 1'b0;
        step(10);
        chk("glitch_ignored", 8'(bus.running), 8'h01);
        bus.btn_run = 1'b1;
        step(5);
        chk("bounce_k4", 8'(bus.running), 8'h01);
        step(1);
        chk("bounce_k5", 8'(bus.running), 8'h01);
        step(1);
        chk("bounce_k6", 8'(bus.running), 8'h00);
        step(10);
        chk("bounce_once", 8'(bus.running), 8'h00);
        bus.btn_run = 1'b0;
        step(8);
        chk("bounce_release", 8'(bus.running), 8'h00);

        // Asynchronous reset mid-run with the count at 37.
        press(1'b0);
        chk("rst_pre_run", 8'(bus.running), 8'h01);
        bus.sw = 8'h37;
        step(3);
        press(1'b1);
        chk("rst_pre_cnt", bus.cnt_data, 8'h37);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_cnt",  bus.cnt_data, 8'h00);
        chk("rst_async_run",  8'(bus.running), 8'h00);
        chk("rst_async_wrap", 8'(bus.wrap), 8'h00);
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("post_rst_cnt", bus.cnt_data, 8'h00);
            chk("post_rst_run", 8'(bus.running), 8'h00);
            chk("post_rst_wrap", 8'(bus.wrap), 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_counter.md
# led_counter

Counting stage that produces the 8-bit `cnt_data` value consumed by `ShowLED`. It turns two raw push-buttons, a direction switch and an 8-bit switch bank into a free-running, pausable, loadable up/down count. The count advances once per prescaled tick. It sits between the board I/O pins and the LED display stage.

## Interface
- `DIV`, 50_000_000: clock cycles per count step; legal range is 2 or more.
- `DB_CYCLES`, 1_000_000: consecutive stable cycles a button must hold before its debounced level changes; legal range is 1 or more.

- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_run`  in  1  raw button; each debounced press toggles run/pause.
- `btn_load`  in  1  raw button; each debounced press loads `sw` into the count.
- `sw`  in  8  load value, asynchronous.
- `up`  in  1  direction, asynchronous: 1 counts up, 0 counts down.
- `cnt_data`  out  8  current count, registered.
- `running`  out  1  high in the RUN state.
- `wrap`  out  1  one-cycle pulse on the count step that wraps 255→0 or 0→255.

## Operation
- Synchronisers: `btn_run`, `btn_load`, `up` and `sw[7:0]` each pass through a 2-FF synchroniser. All later logic uses only the synchronised copies.
- Debounce, per button:
  - The counter clears whenever the synced input equals the debounced level.
  - Otherwise it increments.
  - When it reaches `DB_CYCLES` while still differing, the debounced level flips and the counter clears.
  - A press is a one-cycle pulse on a 0→1 edge of the debounced level. Releases produce nothing.
- State machine: PAUSE (reset state) and RUN.
  - A run press moves PAUSE→RUN or RUN→PAUSE.
  - `running` = (state == RUN).
- Prescaler, range 0..`DIV`-1:
  - Increments only in RUN.
  - At `DIV`-1 it returns to 0 and asserts the internal `tick`.
  - In PAUSE it holds its value, so resuming continues the partial period.
- Count on `tick`:
  - `cnt_data` ← `cnt_data` + 1 when `up`=1, else `cnt_data` − 1.
  - Arithmetic is modulo 256.
  - `wrap` goes high for that cycle when 255→0 (up) or 0→255 (down).
- Load:
  - A load press sets `cnt_data` ← synced `sw` and sets the prescaler to 0. It does not assert `wrap`.
  - Load is accepted in both PAUSE and RUN, and does not change the state.
- Simultaneous events:
  - Load beats tick in the same cycle: the tick is discarded and `wrap` stays 0.
  - A run press and a tick in the same cycle both take effect: the tick is applied, then the state toggles.
  - A direction change applies from the next tick. There is no glitch in `cnt_data`.
- Reset clears everything asynchronously: `cnt_data`=0, `running`=0, `wrap`=0, state PAUSE, prescaler 0, debounce counters and levels 0, synchronisers 0. This holds mid-count or mid-debounce.

## Timing
- All outputs are registered and change only on the `clk` rising edge, except during asynchronous reset.
- Raw button held high from edge k: the press pulse is high in cycle k+2+`DB_CYCLES`.
- Action after a press pulse in cycle p:
  - The state toggle, or the loaded `cnt_data`, is visible from edge p+1.
- Run timing:
  - Entering RUN with prescaler 0 gives the first `cnt_data` change `DIV` cycles after `running` rises.
  - After that, `cnt_data` changes every `DIV` cycles.
- `wrap` is coincident with the `cnt_data` update that wrapped, and lasts exactly 1 cycle.
- A raw button pulse shorter than `DB_CYCLES` synced cycles is ignored completely.

## Structure
- Package `led_counter_pkg` holds:
  - `CNT_W`=8
  - state encoding `PAUSE`=1'b0, `RUN`=1'b1
  - default `DIV` and `DB_CYCLES` constants
- Sub-module `btn_debounce` (parameter `DB_CYCLES`):
  - Contains the synchroniser, debounce counter and rising-edge press pulse.
  - Instantiated twice, for run and load.
- `led_counter` holds the `up`/`sw` synchronisers, the FSM, the prescaler and the count register.
- `cnt_data` connects directly to `ShowLED.cnt_data`.

## Test plan
All scenarios use `DIV`=4 and `DB_CYCLES`=3.
- Reset: assert `rst_n`=0 mid-run with `cnt_data`=8'h37 → immediately `cnt_data`=0, `running`=0, `wrap`=0. After release with no stimulus, outputs stay 0 for 50 cycles.
- Run up: press run, `up`=1 → `running`=1, then `cnt_data` steps 0,1,2… every 4 cycles. At step 255→0, `wrap` is high for exactly 1 cycle.
- Run down: from 0 with `up`=0 → next tick gives 8'hFF with `wrap`=1, then 8'hFE with no `wrap`.
- Bounce: `btn_run` glitches high for 2 cycles, then stable high → exactly one toggle, with the press pulse in cycle k+5 relative to the stable rise.
- Load collision: `sw`=8'hA5 and the load press land in the same cycle as a tick → `cnt_data`=8'hA5 with no `wrap`, then 8'hA6 exactly 4 cycles later.
- Pause/resume: pause with the prescaler at 2, wait 20 cycles → `cnt_data` constant. After resume, the next step occurs 2 cycles after `running` rises.
